// File: rtl/testing_2.sv
// Registered WIDTH-bit adder with carry-in/carry-out.
// The core is two-level carry-lookahead: 4-bit CLA groups, then lookahead across the groups.
module testing_2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);

   localparam int NG = WIDTH / 4;

   logic [WIDTH-1:0] g_s;
   logic [WIDTH-1:0] p_s;
   logic [WIDTH-1:0] sum_s;
   logic [NG-1:0]    gg_s;
   logic [NG-1:0]    gp_s;
   logic [NG:0]      gc_s;

   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic             out_valid_r;

   assign g_s = a & b;
   assign p_s = a ^ b;

   genvar gi;
   generate
      for (gi = 0; gi < NG; gi++) begin : g_grp
         logic [3:0] gl_s;
         logic [3:0] pl_s;
         logic [3:0] cl_s;
         logic       ci_s;

         assign gl_s = g_s[4*gi +: 4];
         assign pl_s = p_s[4*gi +: 4];
         assign ci_s = gc_s[gi];

         assign cl_s[0] = ci_s;
         assign cl_s[1] = gl_s[0] | (pl_s[0] & ci_s);
         assign cl_s[2] = gl_s[1] | (pl_s[1] & gl_s[0]) | (pl_s[1] & pl_s[0] & ci_s);
         assign cl_s[3] = gl_s[2] | (pl_s[2] & gl_s[1]) | (pl_s[2] & pl_s[1] & gl_s[0])
                        | (pl_s[2] & pl_s[1] & pl_s[0] & ci_s);

         // Group generate/propagate never depend on the group carry-in.
         assign gg_s[gi] = gl_s[3] | (pl_s[3] & gl_s[2]) | (pl_s[3] & pl_s[2] & gl_s[1])
                         | (pl_s[3] & pl_s[2] & pl_s[1] & gl_s[0]);
         assign gp_s[gi] = &pl_s;

         assign sum_s[4*gi +: 4] = pl_s ^ cl_s;
      end
   endgenerate

   // Second lookahead level: each group carry-in is a flat sum-of-products of gg/gp and cin.
   always_comb begin
      logic carry_v;
      logic prop_v;
      gc_s    = {(NG+1){1'b0}};
      gc_s[0] = cin;
      for (int k = 0; k < NG; k++) begin
         carry_v = 1'b0;
         prop_v  = 1'b1;
         for (int j = k; j >= 0; j--) begin
            carry_v = carry_v | (prop_v & gg_s[j]);
            prop_v  = prop_v & gp_s[j];
         end
         gc_s[k+1] = carry_v | (prop_v & cin);
      end
   end

   // Output register: reset wins, idle cycles hold the last result but drop out_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_r       <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= in_valid;
         if (in_valid) begin
            sum_r   <= sum_s;
            carry_r <= gc_s[NG];
         end else begin
            sum_r   <= sum_r;
            carry_r <= carry_r;
         end
      end
   end

   assign sum       = sum_r;
   assign carry     = carry_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_testing_2.sv
// Bench for testing_2: scoreboard of expected {out_valid, carry, sum} per cycle.
module tb_testing_2;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             out_valid;

   logic [WIDTH+1:0] exp_q[$];
   logic [WIDTH-1:0] model_sum;
   logic             model_carry;
   int               n_cmp;
   int               n_bad;

   testing_2 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .carry     (carry),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus, push the reference outcome, return at the following negedge.
   task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] ta,
                       input logic [WIDTH-1:0] tb, input logic tc);
      logic [WIDTH:0] full;
      logic           mv;
      rst_n    = r;
      in_valid = v;
      a        = ta;
      b        = tb;
      cin      = tc;
      @(posedge clk);
      full = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
      if (!r) begin
         model_sum   = {WIDTH{1'b0}};
         model_carry = 1'b0;
         mv          = 1'b0;
      end else if (v) begin
         model_sum   = full[WIDTH-1:0];
         model_carry = full[WIDTH];
         mv          = 1'b1;
      end else begin
         mv          = 1'b0;
      end
      exp_q.push_back({mv, model_carry, model_sum});
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [WIDTH+1:0] e;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) step(1'b0, 1'b1, 32'd5, 32'd7, 1'b0);
         else       step(1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
         e = exp_q.pop_front();
         n_cmp++;
         if ({out_valid, carry, sum} !== e) begin
            n_bad++;
            $display("FAIL reset[%0d]: got v=%b c=%b s=%h want v=%b c=%b s=%h",
                     i, out_valid, carry, sum, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
         end
      end
      if (e !== {1'b1, 1'b0, 32'd0}) begin
         n_bad++;
         $display("FAIL reset_model: first result after reset is not valid zero");
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] ta [5] = '{32'd500, 32'd500, 32'd1500, 32'd50000, 32'd500};
      logic [WIDTH-1:0] tb [5] = '{32'd600, 32'd600, 32'd11600, 32'd60020, 32'd600};
      logic             tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [WIDTH+1:0] want [5] = '{{2'b10, 32'd1100}, {2'b10, 32'd1100}, {2'b10, 32'd13101},
                                     {2'b10, 32'd110020}, {2'b10, 32'd1100}};
      logic [WIDTH+1:0] e;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, ta[i], tb[i], tc[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({out_valid, carry, sum} !== want[i] || e !== want[i]) begin
            n_bad++;
            $display("FAIL basic[%0d]: got v=%b c=%b s=%0d want v=%b c=%b s=%0d",
                     i, out_valid, carry, sum, want[i][WIDTH+1], want[i][WIDTH], want[i][WIDTH-1:0]);
         end
      end
   endtask

   task automatic test_hold();
      logic [WIDTH+1:0] e;
      step(1'b1, 1'b0, 32'd1, 32'd1, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, carry, sum} !== {2'b00, 32'd1100}) begin
         n_bad++;
         $display("FAIL hold: got v=%b c=%b s=%0d want v=0 c=0 s=1100 (model %h)",
                  out_valid, carry, sum, e);
      end
   endtask

   task automatic test_wrap();
      logic [WIDTH-1:0] ta [5] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h0000FFFF};
      logic [WIDTH-1:0] tb [5] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
      logic             tc [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [WIDTH+1:0] want [5] = '{{2'b11, 32'h00000000}, {2'b11, 32'h00000000},
                                     {2'b11, 32'hFFFFFFFF}, {2'b10, 32'h80000000},
                                     {2'b10, 32'h00010000}};
      logic [WIDTH+1:0] e;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, ta[i], tb[i], tc[i]);
         e = exp_q.pop_front();
         n_cmp++;
         if ({out_valid, carry, sum} !== want[i] || e !== want[i]) begin
            n_bad++;
            $display("FAIL wrap[%0d]: got v=%b c=%b s=%h want v=%b c=%b s=%h",
                     i, out_valid, carry, sum, want[i][WIDTH+1], want[i][WIDTH], want[i][WIDTH-1:0]);
         end
      end
   endtask

   task automatic test_midreset();
      logic [WIDTH+1:0] e;
      step(1'b0, 1'b1, 32'd3, 32'd4, 1'b0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out_valid, carry, sum} !== {(WIDTH+2){1'b0}}) begin
         n_bad++;
         $display("FAIL midreset: got v=%b c=%b s=%h want v=0 c=0 s=0 (model %h)",
                  out_valid, carry, sum, e);
      end
   endtask

   task automatic test_random();
      logic [WIDTH+1:0] e;
      int               shown;
      shown = 0;
      for (int i = 0; i < 10000; i++) begin
         step(1'b1, 1'b1, $urandom(), $urandom(), 1'($urandom_range(1, 0)));
         e = exp_q.pop_front();
         n_cmp++;
         if ({out_valid, carry, sum} !== e) begin
            n_bad++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random[%0d]: a=%h b=%h cin=%b got v=%b c=%b s=%h want v=%b c=%b s=%h",
                        i, a, b, cin, out_valid, carry, sum, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
            end
         end
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      model_sum   = {WIDTH{1'b0}};
      model_carry = 1'b0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      a           = {WIDTH{1'b0}};
      b           = {WIDTH{1'b0}};
      cin         = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_wrap();
      test_midreset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
